// File: rtl/aquarium_pkg.sv
// Shared select codes, sample ids and scan-state type for the aquarium sensor path.
package aquarium_pkg;

   localparam logic [4:0] SEL_IDLE  = 5'b00000;
   localparam logic [4:0] SEL_CNT   = 5'b00001;
   localparam logic [4:0] SEL_CLEAN = 5'b00010;
   localparam logic [4:0] SEL_TEMP  = 5'b00100;
   localparam logic [4:0] SEL_FOOD  = 5'b01000;
   localparam logic [4:0] SEL_SALT  = 5'b10000;
   localparam logic [4:0] SEL_ERROR = 5'b11111;

   localparam logic [2:0] ID_NONE  = 3'd0;
   localparam logic [2:0] ID_CNT   = 3'd1;
   localparam logic [2:0] ID_CLEAN = 3'd2;
   localparam logic [2:0] ID_TEMP  = 3'd3;
   localparam logic [2:0] ID_FOOD  = 3'd4;
   localparam logic [2:0] ID_SALT  = 3'd5;

   typedef enum logic [2:0] {
      StIdle, StCnt, StClean, StTemp, StFood, StSalt, StError
   } state_e;

   // Mux select code driven while in a given state.
   function automatic logic [4:0] sel_of(input state_e st);
      case (st)
         StCnt:   return SEL_CNT;
         StClean: return SEL_CLEAN;
         StTemp:  return SEL_TEMP;
         StFood:  return SEL_FOOD;
         StSalt:  return SEL_SALT;
         StError: return SEL_ERROR;
         default: return SEL_IDLE;
      endcase
   endfunction

   // Sample id reported for the capture taken in a given slot.
   function automatic logic [2:0] id_of(input state_e st);
      case (st)
         StCnt:   return ID_CNT;
         StClean: return ID_CLEAN;
         StTemp:  return ID_TEMP;
         StFood:  return ID_FOOD;
         StSalt:  return ID_SALT;
         default: return ID_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tank_limit_check.sv
// Combinational limit check of one captured sensor value; limits are strict (equal is in range).
module tank_limit_check
   import aquarium_pkg::*;
#(
   parameter logic [7:0] CLEAN_MIN = 8'd32,
   parameter logic [7:0] TEMP_LO   = 8'd20,
   parameter logic [7:0] TEMP_HI   = 8'd30,
   parameter logic [7:0] FOOD_MIN  = 8'd16,
   parameter logic [7:0] SALT_MAX  = 8'd40
) (
   input  logic [2:0] sample_id_i,
   input  logic [7:0] value_i,
   output logic       alarm_o
);

   // Select the limit rule matching the sensor being sampled.
   always_comb begin
      alarm_o = 1'b0;
      case (sample_id_i)
         ID_CLEAN: alarm_o = (value_i < CLEAN_MIN);
         ID_TEMP:  alarm_o = (value_i < TEMP_LO) || (value_i > TEMP_HI);
         ID_FOOD:  alarm_o = (value_i < FOOD_MIN);
         ID_SALT:  alarm_o = (value_i > SALT_MAX);
         default:  alarm_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/tank_scan_controller.sv
// Scan sequencer around the aquarium sensor mux: walks the select codes, captures samples,
// checks limits, tracks persistent alarms and drops into error mode on faults.
module tank_scan_controller
   import aquarium_pkg::*;
#(
   parameter int unsigned DWELL     = 2,
   parameter logic [7:0]  CLEAN_MIN = 8'd32,
   parameter logic [7:0]  TEMP_LO   = 8'd20,
   parameter logic [7:0]  TEMP_HI   = 8'd30,
   parameter logic [7:0]  FOOD_MIN  = 8'd16,
   parameter logic [7:0]  SALT_MAX  = 8'd40,
   parameter int unsigned ERR_SCANS = 3
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       start_i,
   input  logic       auto_mode_i,
   input  logic       clear_error_i,
   input  logic [7:0] mux_out_i,
   output logic [4:0] mux_select_o,
   output logic [7:0] counter_value_o,
   output logic       sample_valid_o,
   output logic [2:0] sample_id_o,
   output logic [7:0] sample_data_o,
   output logic [3:0] alarm_o,
   output logic       busy_o,
   output logic       error_o
);

   localparam logic [3:0] DwellLast = 4'(DWELL - 1);
   localparam logic [3:0] ErrScans  = 4'(ERR_SCANS);

   state_e     state_q, state_d;
   logic [3:0] dwell_q, dwell_d;
   logic [3:0] persist_q, persist_d;
   logic [7:0] counter_q, counter_d;
   logic [3:0] alarm_q, alarm_d;
   logic [4:0] sel_q, sel_d;
   logic       valid_q, valid_d;
   logic [2:0] id_q, id_d;
   logic [7:0] data_q, data_d;
   logic [2:0] slot_id;
   logic       limit_alarm;

   assign slot_id = id_of(state_q);

   tank_limit_check #(
      .CLEAN_MIN (CLEAN_MIN),
      .TEMP_LO   (TEMP_LO),
      .TEMP_HI   (TEMP_HI),
      .FOOD_MIN  (FOOD_MIN),
      .SALT_MAX  (SALT_MAX)
   ) u_limit (
      .sample_id_i (slot_id),
      .value_i     (mux_out_i),
      .alarm_o     (limit_alarm)
   );

   // Next-state, capture and counter updates for the scan sequence.
   always_comb begin
      state_d   = state_q;
      dwell_d   = dwell_q;
      persist_d = persist_q;
      counter_d = counter_q;
      alarm_d   = alarm_q;
      valid_d   = 1'b0;
      id_d      = id_q;
      data_d    = data_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StCnt;
               dwell_d = '0;
            end
         end
         StCnt, StClean, StTemp, StFood, StSalt: begin
            if (dwell_q != DwellLast) begin
               dwell_d = dwell_q + 4'd1;
            end else begin
               dwell_d = '0;
               valid_d = 1'b1;
               id_d    = slot_id;
               data_d  = mux_out_i;
               unique case (state_q)
                  StCnt:   state_d = (mux_out_i != counter_q) ? StError : StClean;
                  StClean: begin
                     alarm_d[0] = limit_alarm;
                     state_d    = StTemp;
                  end
                  StTemp: begin
                     alarm_d[1] = limit_alarm;
                     state_d    = StFood;
                  end
                  StFood: begin
                     alarm_d[2] = limit_alarm;
                     state_d    = StSalt;
                  end
                  default: begin
                     // End of scan: the salt bit just computed counts toward persistence.
                     alarm_d[3] = limit_alarm;
                     counter_d  = counter_q + 8'd1;
                     persist_d  = (alarm_d != 4'd0) ? persist_q + 4'd1 : 4'd0;
                     if (persist_d == ErrScans) state_d = StError;
                     else state_d = auto_mode_i ? StCnt : StIdle;
                  end
               endcase
            end
         end
         StError: begin
            if (clear_error_i) begin
               state_d   = StIdle;
               persist_d = '0;
               alarm_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
      sel_d = sel_of(state_d);
   end

   // State and datapath registers with asynchronous active-high clear.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         dwell_q   <= '0;
         persist_q <= '0;
         counter_q <= '0;
         alarm_q   <= '0;
         sel_q     <= SEL_IDLE;
         valid_q   <= 1'b0;
         id_q      <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         persist_q <= persist_d;
         counter_q <= counter_d;
         alarm_q   <= alarm_d;
         sel_q     <= sel_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         data_q    <= data_d;
      end
   end

   assign mux_select_o    = sel_q;
   assign counter_value_o = counter_q;
   assign sample_valid_o  = valid_q;
   assign sample_id_o     = id_q;
   assign sample_data_o   = data_q;
   assign alarm_o         = alarm_q;
   assign busy_o          = (state_q != StIdle) && (state_q != StError);
   assign error_o         = (state_q == StError);

endmodule

// File: tb/tb_tank_scan_controller.sv
// Self-checking bench for tank_scan_controller with a behavioural sensor mux and scan model.
module tb_tank_scan_controller;

   localparam int ERR_SCANS = 3;

   logic       CLK = 1'b0;
   logic       reset;
   logic       start, auto_mode, clear_error;
   logic [7:0] mux_out;
   logic [4:0] mux_select;
   logic [7:0] counter_value;
   logic       sample_valid;
   logic [2:0] sample_id;
   logic [7:0] sample_data;
   logic [3:0] alarm;
   logic       busy, error;

   logic [7:0] clean_v, temp_v, food_v, salt_v, loop_val;
   logic       loop_fault;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] cnt_m = 8'd0;
   int         persist_m = 0;
   logic [10:0] samp_q[$];

   tank_scan_controller #(
      .DWELL     (2),
      .CLEAN_MIN (8'd32),
      .TEMP_LO   (8'd20),
      .TEMP_HI   (8'd30),
      .FOOD_MIN  (8'd16),
      .SALT_MAX  (8'd40),
      .ERR_SCANS (ERR_SCANS)
   ) dut (
      .CLK             (CLK),
      .reset           (reset),
      .start_i         (start),
      .auto_mode_i     (auto_mode),
      .clear_error_i   (clear_error),
      .mux_out_i       (mux_out),
      .mux_select_o    (mux_select),
      .counter_value_o (counter_value),
      .sample_valid_o  (sample_valid),
      .sample_id_o     (sample_id),
      .sample_data_o   (sample_data),
      .alarm_o         (alarm),
      .busy_o          (busy),
      .error_o         (error)
   );

   always #5 CLK = ~CLK;

   // Sensor mux model; input1 loops back the scan counter unless a fault is injected.
   always_comb begin
      case (mux_select)
         5'b00001: mux_out = loop_fault ? loop_val : counter_value;
         5'b00010: mux_out = clean_v;
         5'b00100: mux_out = temp_v;
         5'b01000: mux_out = food_v;
         5'b10000: mux_out = salt_v;
         default:  mux_out = 8'h00;
      endcase
   end

   // Record every sample pulse as {id, data}.
   always @(negedge CLK) if (sample_valid) samp_q.push_back({sample_id, sample_data});

   function automatic logic [3:0] model_alarm(input int c, input int t, input int f, input int s);
      return {s > 40, f < 16, (t < 20) || (t > 30), c < 32};
   endfunction

   task automatic pulse_clear();
      @(posedge CLK); #1 clear_error = 1'b1;
      @(posedge CLK); #1 clear_error = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge CLK); reset = 1'b1;
      @(negedge CLK); @(negedge CLK); reset = 1'b0;
      cnt_m = 8'd0;
      persist_m = 0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      checks++; if (mux_select !== 5'b0) begin errors++; $display("FAIL reset_sel got=%b exp=00000", mux_select); end
      checks++; if (counter_value !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%h exp=00", counter_value); end
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
      checks++; if (sample_id !== 3'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", sample_id); end
      checks++; if (sample_data !== 8'd0) begin errors++; $display("FAIL reset_data got=%h exp=00", sample_data); end
      checks++; if (alarm !== 4'd0) begin errors++; $display("FAIL reset_alarm got=%b exp=0000", alarm); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", error); end
      reset = 1'b0;
   endtask

   // One full scan in single-shot mode, checked against the scan model.
   task automatic test_scan(input logic [7:0] c, input logic [7:0] t, input logic [7:0] f,
                            input logic [7:0] s);
      logic [4:0]  seen[11];
      logic [4:0]  exp_sel;
      logic [3:0]  ea;
      logic        ee;
      logic [7:0]  c0;
      logic [7:0]  exp_data[5];
      logic [10:0] e;
      clean_v = c; temp_v = t; food_v = f; salt_v = s;
      auto_mode = 1'b0;
      c0 = cnt_m;
      samp_q.delete();
      @(posedge CLK); #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(negedge CLK);
         seen[i] = mux_select;
      end
      @(negedge CLK);
      ea = model_alarm(c, t, f, s);
      persist_m = (ea != 4'd0) ? persist_m + 1 : 0;
      ee = (persist_m == ERR_SCANS);
      cnt_m = cnt_m + 8'd1;
      for (int i = 0; i < 11; i++) begin
         exp_sel = (i < 10) ? (5'd1 << (i / 2)) : (ee ? 5'b11111 : 5'b00000);
         checks++;
         if (seen[i] !== exp_sel) begin
            errors++; $display("FAIL scan_sel[%0d] got=%b exp=%b", i, seen[i], exp_sel);
         end
      end
      checks++; if (counter_value !== cnt_m) begin errors++; $display("FAIL scan_cnt got=%h exp=%h", counter_value, cnt_m); end
      checks++; if (alarm !== ea) begin errors++; $display("FAIL scan_alarm got=%b exp=%b", alarm, ea); end
      checks++; if (error !== ee) begin errors++; $display("FAIL scan_error got=%b exp=%b", error, ee); end
      checks++;
      if (samp_q.size() != 5) begin
         errors++; $display("FAIL scan_nsamples got=%0d exp=5", samp_q.size());
      end else begin
         exp_data[0] = c0; exp_data[1] = c; exp_data[2] = t; exp_data[3] = f; exp_data[4] = s;
         for (int i = 0; i < 5; i++) begin
            e = samp_q[i];
            checks++;
            if (e !== {3'(i + 1), exp_data[i]}) begin
               errors++;
               $display("FAIL scan_sample[%0d] got=%0d/%h exp=%0d/%h", i, e[10:8], e[7:0], i + 1,
                        exp_data[i]);
            end
         end
      end
      if (ee) begin
         pulse_clear();
         persist_m = 0;
         @(negedge CLK);
         checks++; if (error !== 1'b0 || alarm !== 4'd0) begin errors++; $display("FAIL scan_clear got=%b/%b exp=0/0000", error, alarm); end
      end
   endtask

   task automatic test_persist();
      logic [7:0] c0;
      int         nsalt;
      bit         hit;
      clean_v = 8'd50; temp_v = 8'd31; food_v = 8'd20; salt_v = 8'd30;
      auto_mode = 1'b1;
      c0 = cnt_m;
      samp_q.delete();
      hit = 1'b0;
      @(posedge CLK); #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge CLK);
         if (error) hit = 1'b1;
      end
      @(negedge CLK);
      auto_mode = 1'b0;
      checks++; if (!hit) begin errors++; $display("FAIL persist_timeout got=no_error exp=error"); end
      nsalt = 0;
      foreach (samp_q[i]) if (samp_q[i][10:8] == 3'd5) nsalt++;
      checks++; if (nsalt != ERR_SCANS) begin errors++; $display("FAIL persist_scans got=%0d exp=%0d", nsalt, ERR_SCANS); end
      checks++; if (alarm !== 4'b0010) begin errors++; $display("FAIL persist_alarm got=%b exp=0010", alarm); end
      checks++; if (mux_select !== 5'b11111) begin errors++; $display("FAIL persist_sel got=%b exp=11111", mux_select); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL persist_busy got=%b exp=0", busy); end
      cnt_m = c0 + 8'd3;
      checks++; if (counter_value !== cnt_m) begin errors++; $display("FAIL persist_cnt got=%h exp=%h", counter_value, cnt_m); end
   endtask

   task automatic test_clear_with_start();
      @(posedge CLK); #1 clear_error = 1'b1; start = 1'b1;
      @(posedge CLK); #1 clear_error = 1'b0; start = 1'b0;
      persist_m = 0;
      @(negedge CLK);
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL clr_error got=%b exp=0", error); end
      checks++; if (alarm !== 4'd0) begin errors++; $display("FAIL clr_alarm got=%b exp=0000", alarm); end
      @(negedge CLK);
      checks++; if (busy !== 1'b0 || mux_select !== 5'b0) begin errors++; $display("FAIL clr_nostart got=%b/%b exp=0/00000", busy, mux_select); end
      test_scan(8'd50, 8'd25, 8'd20, 8'd30);
   endtask

   task automatic test_loopback();
      logic [4:0]  seen[3];
      logic [10:0] e;
      apply_reset();
      clean_v = 8'd50; temp_v = 8'd25; food_v = 8'd20; salt_v = 8'd30;
      loop_fault = 1'b1; loop_val = 8'hAA;
      samp_q.delete();
      @(posedge CLK); #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         seen[i] = mux_select;
      end
      checks++; if (seen[1] !== 5'b00001) begin errors++; $display("FAIL loop_sel1 got=%b exp=00001", seen[1]); end
      checks++; if (seen[2] !== 5'b11111 || error !== 1'b1) begin errors++; $display("FAIL loop_err got=%b/%b exp=11111/1", seen[2], error); end
      repeat (4) @(negedge CLK);
      checks++;
      if (samp_q.size() != 1) begin
         errors++; $display("FAIL loop_nsamples got=%0d exp=1", samp_q.size());
      end else begin
         e = samp_q[0];
         checks++; if (e !== {3'd1, 8'hAA}) begin errors++; $display("FAIL loop_sample got=%0d/%h exp=1/aa", e[10:8], e[7:0]); end
      end
      checks++; if (counter_value !== 8'd0) begin errors++; $display("FAIL loop_cnt got=%h exp=00", counter_value); end
      loop_fault = 1'b0;
      pulse_clear();
   endtask

   task automatic test_boundary();
      test_scan(8'd32, 8'd20, 8'd16, 8'd40);
      test_scan(8'd32, 8'd30, 8'd16, 8'd40);
      test_scan(8'd31, 8'd30, 8'd16, 8'd41);
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         test_scan(8'($urandom_range(28, 36)), 8'($urandom_range(17, 33)),
                   8'($urandom_range(12, 20)), 8'($urandom_range(36, 44)));
      end
   endtask

   task automatic test_wrap();
      bit hit_ff, hit_idle;
      apply_reset();
      clean_v = 8'd50; temp_v = 8'd25; food_v = 8'd20; salt_v = 8'd30;
      auto_mode = 1'b1;
      hit_ff = 1'b0; hit_idle = 1'b0;
      @(posedge CLK); #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
      for (int i = 0; i < 3000 && !hit_ff; i++) begin
         @(negedge CLK);
         if (counter_value == 8'hFF) hit_ff = 1'b1;
      end
      auto_mode = 1'b0;
      checks++; if (!hit_ff) begin errors++; $display("FAIL wrap_reach got=%h exp=ff", counter_value); end
      for (int i = 0; i < 30 && !hit_idle; i++) begin
         @(negedge CLK);
         if (!busy) hit_idle = 1'b1;
      end
      checks++; if (!hit_idle || counter_value !== 8'h00) begin errors++; $display("FAIL wrap_cnt got=%h exp=00", counter_value); end
      checks++; if (error !== 1'b0 || mux_select !== 5'b0) begin errors++; $display("FAIL wrap_idle got=%b/%b exp=0/00000", error, mux_select); end
      cnt_m = 8'd0;
   endtask

   task automatic test_reset_mid();
      bit hit;
      clean_v = 8'd50; temp_v = 8'd25; food_v = 8'd20; salt_v = 8'd30;
      hit = 1'b0;
      @(posedge CLK); #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge CLK);
         if (mux_select == 5'b00100) hit = 1'b1;
      end
      checks++; if (!hit) begin errors++; $display("FAIL mid_reach got=%b exp=00100", mux_select); end
      #1 reset = 1'b1;
      #1;
      samp_q.delete();
      checks++;
      if ({mux_select, counter_value, sample_valid, sample_id, sample_data, alarm, busy, error} !== '0) begin
         errors++;
         $display("FAIL mid_reset got=sel%b cnt%h v%b id%0d d%h al%b b%b e%b exp=all0", mux_select,
                  counter_value, sample_valid, sample_id, sample_data, alarm, busy, error);
      end
      @(negedge CLK); @(negedge CLK); reset = 1'b0;
      repeat (10) @(negedge CLK);
      checks++; if (samp_q.size() != 0 || busy !== 1'b0) begin errors++; $display("FAIL mid_after got=%0d/%b exp=0/0", samp_q.size(), busy); end
      cnt_m = 8'd0; persist_m = 0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; auto_mode = 1'b0; clear_error = 1'b0;
      clean_v = 8'd50; temp_v = 8'd25; food_v = 8'd20; salt_v = 8'd30;
      loop_fault = 1'b0; loop_val = 8'h00;
      repeat (2) @(negedge CLK);
      test_reset();
      test_scan(8'd50, 8'd25, 8'd20, 8'd30);
      test_persist();
      test_clear_with_start();
      test_loopback();
      test_boundary();
      test_random();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
